dmem_access_unit: RTL

//  Multi-cycle data-memory access stage sitting between the execute/mem pipeline

---
 rtl/mem_pkg.sv | 30 +++
 rtl/store_format.sv | 33 +++
 rtl/dmem_access_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared data-memory definitions: access size encodings, access-unit state type
// and the alignment rule used when a request is accepted.
`timescale 1ns/1ps
package mem_pkg;

  localparam logic [1:0] MEM_BYTE     = 2'b00;
  localparam logic [1:0] MEM_HALF     = 2'b01;
  localparam logic [1:0] MEM_WORD     = 2'b10;
  localparam int         MEM_UNSIGNED = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } dmem_state_t;

  // Size 2'b11 falls into the word rule, matching the store formatter.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_low);
    logic mis;
    case (size)
      MEM_BYTE: mis = 1'b0;
      MEM_HALF: mis = addr_low[0];
      default:  mis = (addr_low != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/store_format.sv
// Combinational store lane formatter: byte enables and replicated lane data
// derived from access size and the low address bits.
`timescale 1ns/1ps
module store_format
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_low,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] lane_data
);

  always_comb begin
    be        = 4'b0000;
    lane_data = 32'h0;
    case (size)
      MEM_BYTE: begin
        be        = 4'b0001 << addr_low;
        lane_data = {4{wdata[7:0]}};
      end
      MEM_HALF: begin
        be        = addr_low[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        lane_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Multi-cycle load/store access stage: captures one request, runs the
// req/gnt/rvalid bus handshake and hands a registered response to the formatter.
`timescale 1ns/1ps
module dmem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter bit STORE_WAIT_ACK = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_mem_ctrl,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_addr_low,
  output logic [2:0]  rsp_mem_ctrl,
  output logic        rsp_misalign,
  output logic        rsp_bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  dmem_state_t  state;
  logic         we_q;
  logic [29:0]  word_addr_q;
  logic [3:0]   be_q;
  logic [31:0]  wdata_q;
  logic [1:0]   addr_low_q;
  logic [2:0]   mem_ctrl_q;
  logic [31:0]  rdata_q;
  logic         misalign_q;
  logic         bus_err_q;
  logic [CNT_W-1:0] tcnt;

  logic [3:0]   fmt_be;
  logic [31:0]  fmt_data;
  logic         accept;
  logic         misaligned;
  logic         timeout_hit;
  logic         in_req;

  store_format u_store_format (
    .size      (req_mem_ctrl[1:0]),
    .addr_low  (req_addr[1:0]),
    .wdata     (req_wdata),
    .be        (fmt_be),
    .lane_data (fmt_data)
  );

  assign accept      = req_valid && (state == ST_IDLE);
  assign misaligned  = is_misaligned(req_mem_ctrl[1:0], req_addr[1:0]);
  // The counter value seen here is the number of REQ/WAIT cycles already spent.
  assign timeout_hit = (tcnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign in_req      = (state == ST_REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      we_q        <= 1'b0;
      word_addr_q <= 30'h0;
      be_q        <= 4'h0;
      wdata_q     <= 32'h0;
      addr_low_q  <= 2'b00;
      mem_ctrl_q  <= 3'b000;
      rdata_q     <= 32'h0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      tcnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            we_q        <= req_we;
            word_addr_q <= req_addr[31:2];
            be_q        <= req_we ? fmt_be : 4'b1111;
            wdata_q     <= req_we ? fmt_data : 32'h0;
            addr_low_q  <= req_addr[1:0];
            mem_ctrl_q  <= req_mem_ctrl;
            rdata_q     <= 32'h0;
            misalign_q  <= misaligned;
            bus_err_q   <= 1'b0;
            tcnt        <= '0;
            state       <= misaligned ? ST_RESP : ST_REQ;
          end
        end
        ST_REQ: begin
          tcnt <= tcnt + CNT_W'(1);
          if (dmem_gnt) begin
            state <= (!we_q || STORE_WAIT_ACK) ? ST_WAIT : ST_RESP;
          end else if (timeout_hit) begin
            bus_err_q <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_WAIT: begin
          tcnt <= tcnt + CNT_W'(1);
          if (dmem_rvalid) begin
            rdata_q <= we_q ? 32'h0 : dmem_rdata;
            state   <= ST_RESP;
          end else if (timeout_hit) begin
            bus_err_q <= 1'b1;
            state     <= ST_RESP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready    = (state == ST_IDLE);
  assign stall        = (state != ST_IDLE);
  assign dmem_req     = in_req;
  assign dmem_we      = in_req & we_q;
  assign dmem_addr    = in_req ? {word_addr_q, 2'b00} : 32'h0;
  assign dmem_be      = in_req ? be_q : 4'h0;
  assign dmem_wdata   = in_req ? wdata_q : 32'h0;
  assign rsp_valid    = (state == ST_RESP);
  assign rsp_rdata    = rdata_q;
  assign rsp_addr_low = addr_low_q;
  assign rsp_mem_ctrl = mem_ctrl_q;
  assign rsp_misalign = rsp_valid & misalign_q;
  assign rsp_bus_err  = rsp_valid & bus_err_q;

endmodule
